// File: rtl/phit_gearbox.sv
// Phit width converter between IN_W and OUT_W bit valid/ready streams.
// Packs narrow phits into wide ones, or splits wide phits into segments.
`timescale 1ns/1ps
module phit_gearbox #(
   parameter int unsigned IN_W  = 256,
   parameter int unsigned OUT_W = 512,
   localparam int unsigned SEG_W = (IN_W < OUT_W) ? IN_W : OUT_W,
   localparam int unsigned IN_K  = IN_W / SEG_W,
   localparam int unsigned OUT_K = OUT_W / SEG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   input  logic [IN_K-1:0]  in_keep,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic [OUT_K-1:0] out_keep,
   output logic             out_last,
   input  logic             out_ready,
   output logic             err_keep
);

   localparam int unsigned RATIO = ((IN_W > OUT_W) ? IN_W : OUT_W) / SEG_W;
   localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned NW    = $clog2(RATIO + 1);

   if ((((IN_W > OUT_W) ? IN_W : OUT_W) % SEG_W) != 0) begin : g_bad_ratio
      $error("phit_gearbox: larger width must be an integer multiple of the smaller");
   end

   if (OUT_W > IN_W) begin : g_up
      typedef enum logic [0:0] {S_ACCUM = 1'b0, S_HOLD = 1'b1} state_t;

      state_t             r_state;
      logic [CW-1:0]      r_cnt;
      logic [OUT_W-1:0]   r_acc;
      logic [OUT_K-1:0]   r_acc_keep;
      logic [OUT_W-1:0]   r_out_data;
      logic [OUT_K-1:0]   r_out_keep;
      logic               r_out_last;
      logic               r_err;
      logic [OUT_W-1:0]   w_fill_data;
      logic [OUT_K-1:0]   w_fill_keep;
      logic               w_in_fire;
      logic               w_out_fire;
      logic               w_done;

      assign out_valid  = (r_state == S_HOLD);
      assign in_ready   = !rst && ((r_state == S_ACCUM) || out_ready);
      assign w_in_fire  = in_valid && in_ready;
      assign w_out_fire = out_valid && out_ready;
      assign w_done     = (r_cnt == CW'(RATIO - 1)) || in_last;

      // Accumulator with the incoming phit dropped into slot r_cnt
      always_comb begin
         w_fill_data = r_acc;
         w_fill_keep = r_acc_keep;
         for (int s = 0; s < int'(RATIO); s++) begin
            if (r_cnt == CW'(s)) begin
               w_fill_data[s*SEG_W +: SEG_W] = in_data;
               w_fill_keep[s]                = in_keep[0];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_state    <= S_ACCUM;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_acc_keep <= '0;
            r_out_data <= '0;
            r_out_keep <= '0;
            r_out_last <= 1'b0;
            r_err      <= 1'b0;
         end else begin
            if (w_out_fire) r_state <= S_ACCUM;
            if (w_in_fire) begin
               if (!in_keep[0]) begin
                  r_err <= 1'b1;
               end else if (w_done) begin
                  r_state    <= S_HOLD;
                  r_out_data <= w_fill_data;
                  r_out_keep <= w_fill_keep;
                  r_out_last <= in_last;
                  r_cnt      <= '0;
                  r_acc      <= '0;
                  r_acc_keep <= '0;
               end else begin
                  r_acc      <= w_fill_data;
                  r_acc_keep <= w_fill_keep;
                  r_cnt      <= r_cnt + CW'(1);
               end
            end
         end
      end

      assign out_data = r_out_data;
      assign out_keep = r_out_keep;
      assign out_last = r_out_last;
      assign err_keep = r_err;
   end else begin : g_narrow
      logic [NW-1:0] w_run;
      logic [NW-1:0] w_n;
      logic          w_stop;
      logic          w_nonc;
      logic          w_zero;
      logic          w_kerr;

      // Keep decode: run of ones from bit 0; a non-zero keep always yields segment 0
      always_comb begin
         w_run  = '0;
         w_stop = 1'b0;
         w_nonc = 1'b0;
         for (int i = 0; i < int'(IN_K); i++) begin
            if (!in_keep[i])  w_stop = 1'b1;
            else if (w_stop)  w_nonc = 1'b1;
            else              w_run  = w_run + NW'(1);
         end
         w_zero = (in_keep == '0);
         w_kerr = w_zero || w_nonc;
         w_n    = ((w_run == '0) && !w_zero) ? NW'(1) : w_run;
      end

      if (IN_W > OUT_W) begin : g_down
         logic [IN_W-1:0]  r_buf;
         logic [NW-1:0]    r_n;
         logic [CW-1:0]    r_idx;
         logic             r_blast;
         logic             r_valid;
         logic [SEG_W-1:0] r_data;
         logic [OUT_K-1:0] r_keep;
         logic             r_last;
         logic             r_err;
         logic [CW-1:0]    w_nidx;
         logic [SEG_W-1:0] w_nseg;
         logic             w_lastseg;
         logic             w_in_fire;
         logic             w_out_fire;

         assign w_lastseg  = (NW'(r_idx) + NW'(1) == r_n);
         assign w_out_fire = r_valid && out_ready;
         assign in_ready   = !rst && (!r_valid || (out_ready && w_lastseg));
         assign w_in_fire  = in_valid && in_ready;
         assign w_nidx     = r_idx + CW'(1);

         always_comb begin
            w_nseg = r_buf[SEG_W-1:0];
            for (int s = 0; s < int'(RATIO); s++) begin
               if (w_nidx == CW'(s)) w_nseg = r_buf[s*SEG_W +: SEG_W];
            end
         end

         // The output register is preloaded with the segment to present next
         always_ff @(posedge clk) begin
            if (rst) begin
               r_buf   <= '0;
               r_n     <= '0;
               r_idx   <= '0;
               r_blast <= 1'b0;
               r_valid <= 1'b0;
               r_data  <= '0;
               r_keep  <= '0;
               r_last  <= 1'b0;
               r_err   <= 1'b0;
            end else begin
               if (w_out_fire) begin
                  if (w_lastseg) begin
                     r_valid <= 1'b0;
                  end else begin
                     r_idx  <= w_nidx;
                     r_data <= w_nseg;
                     r_last <= r_blast && (NW'(w_nidx) + NW'(1) == r_n);
                  end
               end
               if (w_in_fire) begin
                  if (w_kerr) r_err <= 1'b1;
                  if (!w_zero) begin
                     r_buf   <= in_data;
                     r_n     <= w_n;
                     r_idx   <= '0;
                     r_blast <= in_last;
                     r_valid <= 1'b1;
                     r_data  <= in_data[SEG_W-1:0];
                     r_keep  <= OUT_K'(1);
                     r_last  <= in_last && (w_n == NW'(1));
                  end
               end
            end
         end

         assign out_valid = r_valid;
         assign out_data  = r_data;
         assign out_keep  = r_keep;
         assign out_last  = r_last;
         assign err_keep  = r_err;
      end else begin : g_pass
         logic             r_valid;
         logic [OUT_W-1:0] r_data;
         logic [OUT_K-1:0] r_keep;
         logic             r_last;
         logic             r_err;
         logic [OUT_K-1:0] w_mask;
         logic             w_in_fire;
         logic             w_out_fire;

         assign in_ready   = !rst && (!r_valid || out_ready);
         assign w_in_fire  = in_valid && in_ready;
         assign w_out_fire = r_valid && out_ready;

         always_comb begin
            w_mask = '0;
            for (int i = 0; i < int'(OUT_K); i++) w_mask[i] = (NW'(i) < w_n);
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_valid <= 1'b0;
               r_data  <= '0;
               r_keep  <= '0;
               r_last  <= 1'b0;
               r_err   <= 1'b0;
            end else begin
               if (w_out_fire) r_valid <= 1'b0;
               if (w_in_fire) begin
                  if (w_kerr) r_err <= 1'b1;
                  if (!w_zero) begin
                     r_valid <= 1'b1;
                     r_data  <= in_data;
                     r_keep  <= w_mask;
                     r_last  <= in_last;
                  end
               end
            end
         end

         assign out_valid = r_valid;
         assign out_data  = r_data;
         assign out_keep  = r_keep;
         assign out_last  = r_last;
         assign err_keep  = r_err;
      end
   end

endmodule

// File: tb/tb_phit_gearbox.sv
// Scoreboard bench for phit_gearbox: a 128->512 upsizer and a 512->128 downsizer.
`timescale 1ns/1ps
module tb_phit_gearbox;

   localparam int unsigned SW = 128;
   localparam int unsigned UO = 512;
   localparam int unsigned DI = 512;
   localparam int unsigned R  = 4;

   typedef struct packed {
      logic [UO-1:0] data;
      logic [R-1:0]  keep;
      logic          last;
   } uexp_t;

   typedef struct packed {
      logic [SW-1:0] data;
      logic          last;
   } dexp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned cyc   = 0;
   always @(posedge clk) cyc++;

   logic          u_rst, u_in_valid, u_in_last, u_in_ready, u_out_valid, u_out_last, u_out_ready, u_err;
   logic [SW-1:0] u_in_data;
   logic [0:0]    u_in_keep;
   logic [UO-1:0] u_out_data;
   logic [R-1:0]  u_out_keep;

   logic          d_rst, d_in_valid, d_in_last, d_in_ready, d_out_valid, d_out_last, d_out_ready, d_err;
   logic [DI-1:0] d_in_data;
   logic [R-1:0]  d_in_keep;
   logic [SW-1:0] d_out_data;
   logic [0:0]    d_out_keep;

   phit_gearbox #(.IN_W(SW), .OUT_W(UO)) u_dut (
      .clk(clk), .rst(u_rst),
      .in_valid(u_in_valid), .in_data(u_in_data), .in_keep(u_in_keep), .in_last(u_in_last),
      .in_ready(u_in_ready),
      .out_valid(u_out_valid), .out_data(u_out_data), .out_keep(u_out_keep), .out_last(u_out_last),
      .out_ready(u_out_ready), .err_keep(u_err)
   );

   phit_gearbox #(.IN_W(DI), .OUT_W(SW)) d_dut (
      .clk(clk), .rst(d_rst),
      .in_valid(d_in_valid), .in_data(d_in_data), .in_keep(d_in_keep), .in_last(d_in_last),
      .in_ready(d_in_ready),
      .out_valid(d_out_valid), .out_data(d_out_data), .out_keep(d_out_keep), .out_last(d_out_last),
      .out_ready(d_out_ready), .err_keep(d_err)
   );

   uexp_t         uq[$];
   dexp_t         dq[$];
   logic [SW-1:0] u_pend[$];
   logic          u_err_exp = 1'b0;
   logic          d_err_exp = 1'b0;
   bit            u_rnd = 1'b0;
   bit            d_rnd = 1'b0;
   int unsigned   u_fire_cyc, d_fire_cyc;

   task automatic chk(input string name, input logic [UO-1:0] act, input logic [UO-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: segments gather until four are held or a last arrives
   function automatic void u_model(input logic [SW-1:0] d, input logic k, input logic l);
      uexp_t e;
      if (!k) begin
         u_err_exp = 1'b1;
         return;
      end
      u_pend.push_back(d);
      if (u_pend.size() == R || l) begin
         e = '0;
         for (int i = 0; i < u_pend.size(); i++) begin
            e.data[i*SW +: SW] = u_pend[i];
            e.keep[i]          = 1'b1;
         end
         e.last = l;
         uq.push_back(e);
         u_pend.delete();
      end
   endfunction

   // Reference: emit the leading run of kept segments, last tagged on the final one
   function automatic void d_model(input logic [DI-1:0] d, input logic [R-1:0] k, input logic l);
      int run = 0;
      dexp_t e;
      while (run < int'(R) && k[run]) run++;
      if (k != R'((1 << run) - 1) || k == '0) d_err_exp = 1'b1;
      if (k == '0) return;
      if (run == 0) run = 1;
      for (int i = 0; i < run; i++) begin
         e.data = d[i*SW +: SW];
         e.last = l && (i == run - 1);
         dq.push_back(e);
      end
   endfunction

   task automatic u_send(input logic [SW-1:0] d, input logic k, input logic l);
      bit ok = 1'b0;
      u_in_valid = 1'b1; u_in_data = d; u_in_keep = k; u_in_last = l;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (u_in_ready) begin
            ok = 1'b1; u_fire_cyc = cyc; u_model(d, k, l);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      u_in_valid = 1'b0;
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL u_send_timeout: in_ready never rose for data %0h", d);
      end
   endtask

   task automatic d_send(input logic [DI-1:0] d, input logic [R-1:0] k, input logic l);
      bit ok = 1'b0;
      d_in_valid = 1'b1; d_in_data = d; d_in_keep = k; d_in_last = l;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (d_in_ready) begin
            ok = 1'b1; d_fire_cyc = cyc; d_model(d, k, l);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL d_send_timeout: in_ready never rose, keep %0h", k);
      end
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 5000; t++) begin
         @(negedge clk);
         if (uq.size() == 0 && dq.size() == 0 && !u_out_valid && !d_out_valid) break;
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [SW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always @(posedge clk) begin
      #1;
      u_out_ready = u_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      d_out_ready = d_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Upsize monitor: pops on every handshake, checks hold-stability on stalls
   logic [UO-1:0] u_pd;
   logic [R-1:0]  u_pk;
   logic          u_pl;
   bit            u_stall = 1'b0;
   always @(negedge clk) begin
      uexp_t e;
      if (u_rst) begin
         u_stall = 1'b0;
      end else begin
         if (u_stall) begin
            chk("u_stall_valid", UO'(u_out_valid), UO'(1));
            chk("u_stall_data", u_out_data, u_pd);
            chk("u_stall_keep", UO'(u_out_keep), UO'(u_pk));
            chk("u_stall_last", UO'(u_out_last), UO'(u_pl));
         end
         if (u_out_valid && u_out_ready) begin
            if (uq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL u_extra: unexpected output %0h", u_out_data);
            end else begin
               e = uq.pop_front();
               chk("u_data", u_out_data, e.data);
               chk("u_keep", UO'(u_out_keep), UO'(e.keep));
               chk("u_last", UO'(u_out_last), UO'(e.last));
            end
         end
         u_stall = u_out_valid && !u_out_ready;
         u_pd = u_out_data; u_pk = u_out_keep; u_pl = u_out_last;
      end
   end

   // Downsize monitor
   logic [SW-1:0] d_pd;
   logic          d_pl;
   bit            d_stall = 1'b0;
   always @(negedge clk) begin
      dexp_t e;
      if (d_rst) begin
         d_stall = 1'b0;
      end else begin
         if (d_stall) begin
            chk("d_stall_valid", UO'(d_out_valid), UO'(1));
            chk("d_stall_data", UO'(d_out_data), UO'(d_pd));
            chk("d_stall_last", UO'(d_out_last), UO'(d_pl));
         end
         if (d_out_valid && d_out_ready) begin
            if (dq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL d_extra: unexpected output %0h", d_out_data);
            end else begin
               e = dq.pop_front();
               chk("d_data", UO'(d_out_data), UO'(e.data));
               chk("d_keep", UO'(d_out_keep), UO'(1));
               chk("d_last", UO'(d_out_last), UO'(e.last));
            end
         end
         d_stall = d_out_valid && !d_out_ready;
         d_pd = d_out_data; d_pl = d_out_last;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SW-1:0] a, b, c;
      logic [DI-1:0] p, q, s;
      int unsigned   t0;
      int            nseg;
      logic [R-1:0]  k;

      u_rst = 1'b1; d_rst = 1'b1;
      u_in_valid = 1'b0; u_in_data = '0; u_in_keep = '0; u_in_last = 1'b0;
      d_in_valid = 1'b0; d_in_data = '0; d_in_keep = '0; d_in_last = 1'b0;
      u_out_ready = 1'b1; d_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("u_rst_in_ready", UO'(u_in_ready), UO'(0));
      chk("d_rst_in_ready", UO'(d_in_ready), UO'(0));
      @(posedge clk); #1;
      u_rst = 1'b0; d_rst = 1'b0;
      @(negedge clk);
      chk("u_rst_valid", UO'(u_out_valid), UO'(0));
      chk("u_rst_data", u_out_data, UO'(0));
      chk("u_rst_keep_last_err", UO'({u_out_keep, u_out_last, u_err}), UO'(0));
      chk("d_rst_valid", UO'(d_out_valid), UO'(0));
      chk("d_rst_data", UO'(d_out_data), UO'(0));
      chk("d_rst_keep_last_err", UO'({d_out_keep, d_out_last, d_err}), UO'(0));
      @(posedge clk); #1;

      // Upsize: two-segment packet, then a one-segment packet
      a = rnd128(); b = rnd128(); c = rnd128();
      u_send(a, 1'b1, 1'b0);
      @(negedge clk);
      chk("u_partial_no_valid", UO'(u_out_valid), UO'(0));
      @(posedge clk); #1;
      u_send(b, 1'b1, 1'b1);
      @(negedge clk);
      chk("u_ab_latency_valid", UO'(u_out_valid), UO'(1));
      chk("u_ab_data", u_out_data, {UO'(0), b, a} & {UO{1'b1}});
      chk("u_ab_keep_last", UO'({u_out_keep, u_out_last}), UO'({4'b0011, 1'b1}));
      @(posedge clk); #1;
      u_send(c, 1'b1, 1'b1);
      @(negedge clk);
      chk("u_c_data", u_out_data, UO'(c));
      chk("u_c_keep_last", UO'({u_out_keep, u_out_last}), UO'({4'b0001, 1'b1}));
      @(posedge clk); #1;
      u_send(rnd128(), 1'b1, 1'b0);
      u_send(rnd128(), 1'b1, 1'b1);
      wait_drain();

      // Downsize: full phits back to back, then short and malformed keeps
      p = {rnd128(), rnd128(), rnd128(), rnd128()};
      q = {rnd128(), rnd128(), rnd128(), rnd128()};
      s = {rnd128(), rnd128(), rnd128(), rnd128()};
      d_send(p, 4'b1111, 1'b1);
      t0 = d_fire_cyc;
      d_send(q, 4'b1111, 1'b1);
      chk("d_no_bubble_gap", UO'(d_fire_cyc - t0), UO'(R));
      wait_drain();
      d_send(s, 4'b0001, 1'b1);
      @(negedge clk);
      chk("d_single_valid", UO'(d_out_valid), UO'(1));
      chk("d_single_data", UO'(d_out_data), UO'(s[SW-1:0]));
      chk("d_single_last", UO'(d_out_last), UO'(1));
      @(negedge clk);
      chk("d_single_only_one", UO'(d_out_valid), UO'(0));
      chk("d_err_clean", UO'(d_err), UO'(0));
      @(posedge clk); #1;
      d_send(q, 4'b0010, 1'b1);
      @(negedge clk);
      chk("d_noncontig_err", UO'(d_err), UO'(1));
      chk("d_noncontig_data", UO'(d_out_data), UO'(q[SW-1:0]));
      chk("d_noncontig_last", UO'(d_out_last), UO'(1));
      @(posedge clk); #1;
      wait_drain();

      // Random traffic with 50% output backpressure
      u_rnd = 1'b1;
      for (int pk = 0; pk < 1000; pk++) begin
         nseg = $urandom_range(1, 9);
         for (int sg = 0; sg < nseg; sg++) begin
            u_send(rnd128(), 1'($urandom_range(0, 19) != 0), sg == nseg - 1);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         end
      end
      wait_drain();
      u_rnd = 1'b0;

      d_rnd = 1'b1;
      for (int pk = 0; pk < 1000; pk++) begin
         nseg = $urandom_range(1, 3);
         for (int ph = 0; ph < nseg; ph++) begin
            if ($urandom_range(0, 15) == 0) k = R'($urandom_range(0, 15));
            else k = R'((1 << $urandom_range(1, 4)) - 1);
            d_send({rnd128(), rnd128(), rnd128(), rnd128()}, k, ph == nseg - 1);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         end
      end
      wait_drain();
      d_rnd = 1'b0;
      chk("u_err_sticky", UO'(u_err), UO'(u_err_exp));
      chk("d_err_sticky", UO'(d_err), UO'(d_err_exp));

      // Reset with two of four segments accumulated
      if (u_pend.size() != 0) begin
         u_send(rnd128(), 1'b1, 1'b1);
         wait_drain();
      end
      u_send(rnd128(), 1'b1, 1'b0);
      u_send(rnd128(), 1'b1, 1'b0);
      u_rst = 1'b1;
      u_pend.delete();
      u_err_exp = 1'b0;
      @(negedge clk);
      chk("u_midrst_in_ready", UO'(u_in_ready), UO'(0));
      @(posedge clk); #1;
      u_rst = 1'b0;
      @(negedge clk);
      chk("u_midrst_valid", UO'(u_out_valid), UO'(0));
      chk("u_midrst_data", u_out_data, UO'(0));
      chk("u_midrst_keep_last_err", UO'({u_out_keep, u_out_last, u_err}), UO'(0));
      @(posedge clk); #1;
      for (int i = 0; i < int'(R); i++) u_send(rnd128(), 1'b1, 1'b0);
      wait_drain();

      chk("u_queue_empty", UO'(uq.size()), UO'(0));
      chk("d_queue_empty", UO'(dq.size()), UO'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/phit_gearbox.md
# phit_gearbox

Parametrised phit width converter for the network datapath. It converts a valid/ready phit stream from IN_W bits to OUT_W bits, where one width is an integer multiple of the other. It packs narrow phits into wide ones (upsize) or splits wide phits into narrow ones (downsize), carrying packet boundaries and a per-segment keep mask. It generalises the fixed 256b/512b phit choice so that links of different phit sizes can be bridged in one design.

## Interface
- IN_W, 256, input phit width in bits.
- OUT_W, 512, output phit width in bits.
- Derived: SEG_W = min(IN_W, OUT_W); RATIO = max(IN_W, OUT_W) / SEG_W; IN_K = IN_W/SEG_W; OUT_K = OUT_W/SEG_W. Elaboration error unless max % min == 0.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input phit valid.
- in_data  in  IN_W  input phit; segment 0 is bits [SEG_W-1:0] and is first on the wire.
- in_keep  in  IN_K  per-segment valid mask; must be contiguous from bit 0.
- in_last  in  1  final phit of packet.
- in_ready  out  1  input accepted when in_valid && in_ready.
- out_valid  out  1  output phit valid.
- out_data  out  OUT_W  output phit.
- out_keep  out  OUT_K  per-segment valid mask, contiguous from bit 0.
- out_last  out  1  final phit of packet.
- out_ready  in  1  output accepted when out_valid && out_ready.
- err_keep  out  1  sticky: a non-contiguous or all-zero in_keep was accepted.

## Operation
- Reset values: out_valid=0, out_data=0, out_keep=0, out_last=0, err_keep=0. in_ready=0 while rst is high.
- Pass mode (IN_W==OUT_W): single register stage. Data, keep and last are copied unchanged.
- Upsize mode (OUT_W>IN_W):
  - States ACCUM and HOLD. A segment counter cnt runs 0..RATIO-1.
  - An accepted input is written into segment slot cnt, and keep bit cnt gets in_keep[0].
  - The phit completes when cnt==RATIO-1 or in_last=1. On completion, go to HOLD: out_valid=1, out_last=in_last, unfilled slots are zero data with keep=0, and cnt resets to 0.
  - in_ready = !out_valid || out_ready. When the output handshakes and an input is accepted in the same cycle, the input starts the next phit at slot 0.
- Downsize mode (IN_W>OUT_W):
  - A single buffer holds one input phit plus n = number of kept segments, and an index idx.
  - out_data is segment idx; out_keep=1; out_last = buffer last && idx==n-1.
  - Each output handshake increments idx. On idx==n-1 the buffer empties.
  - Segments with keep=0 are never emitted.
  - in_ready = buffer empty || (out handshake && idx==n-1). This allows back-to-back refill with no bubble.
- Keep errors:
  - Non-contiguous in_keep: err_keep is set and only the contiguous run from bit 0 is used.
  - All-zero in_keep: err_keep is set and the phit is dropped. If it carries in_last, the last flag is lost.
  - err_keep clears only on rst.
- Non-last phits with partial keep are legal and are forwarded as-is (no repacking across phits).

## Timing
- Latency: out_valid asserts 1 cycle after the input handshake that completes (upsize) or loads (downsize/pass) a phit.
- Throughput: upsize 1 input/cycle; downsize 1 output/cycle; pass 1/cycle. No idle cycles under continuous valid/ready.
- Stability: while out_valid && !out_ready, out_data, out_keep and out_last stay stable and out_valid does not drop.
- in_ready depends combinationally on out_ready; there is no combinational path from in_* to out_*.
- Reset mid-packet: partial accumulator or buffer contents are discarded, and the next accepted phit starts at slot/idx 0 as a new packet.

## Test plan
- Upsize 256->512: A (keep 1, last 0) then B (keep 1, last 1) -> one output {B,A}, keep 2'b11, last=1, 1 cycle after B is accepted.
- Upsize 256->512: single phit C with last=1 -> output {0,C}, keep 2'b01, last=1. A following D,E pair packs normally.
- Downsize 512->256, keep 2'b11, last=1, out_ready=1 -> lo segment (last=0) then hi segment (last=1) on consecutive cycles. in_ready stays high to accept the next phit with no bubble.
- Downsize with keep 2'b01 and last=1 -> exactly one output, the lo segment, with last=1. in keep 2'b10 -> err_keep=1, lo segment emitted.
- Random out_ready backpressure (50%) over 1000 packets in 128->512 and 512->128 -> outputs held stable while stalled; scoreboard byte stream and last positions match exactly.
- Assert rst for 1 cycle after 2 of 4 segments are accumulated in 128->512 -> no output from the partial phit; outputs return to their reset values; the next 4 inputs produce one correct phit.
